// File: rtl/seq_comparator.sv
// Multi-cycle RV32I branch comparator that evaluates one CHUNK-bit slice per cycle, MSB slice first.
// Define SEQ_COMPARATOR_EARLY_EXIT_EN to finish as soon as the first differing slice is seen.
module seq_comparator #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_valid_i,
    output logic             start_ready_o,
    input  logic [2:0]       funct3_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_valid_o,
    input  logic             done_ready_i,
    output logic             taken_o,
    output logic             lt_o,
    output logic             eq_o
);

    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] KLast = KW'(N - 1);
`ifdef SEQ_COMPARATOR_EARLY_EXIT_EN
    localparam bit EarlyExit = 1'b1;
`else
    localparam bit EarlyExit = 1'b0;
`endif

    if (CHUNK == 0 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
        $error("seq_comparator: WIDTH must be a non-zero multiple of CHUNK");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       funct3_q;
    logic [KW-1:0]    k_q;
    logic             dec_q, lt_q, eq_q, taken_q, done_valid_q;

    logic [CHUNK-1:0] slice_a, slice_b;
    logic             hit, lt_nxt, eq_nxt, taken_nxt, last, accept;

    assign start_ready_o = (state_q == StIdle) || (state_q == StDone && done_ready_i);
    assign accept        = start_valid_i && start_ready_o;

    // Operands shift left each RUN cycle, so the slice under test is always the top one.
    always_comb begin
        slice_a = a_q[WIDTH-1 -: CHUNK];
        slice_b = b_q[WIDTH-1 -: CHUNK];
        if (k_q == '0 && !funct3_q[1]) begin
            slice_a[CHUNK-1] = ~slice_a[CHUNK-1];
            slice_b[CHUNK-1] = ~slice_b[CHUNK-1];
        end
    end

    always_comb begin
        hit    = !dec_q && (slice_a != slice_b);
        lt_nxt = hit ? (slice_a < slice_b) : lt_q;
        eq_nxt = eq_q && !hit;
        last   = (k_q == KLast) || (EarlyExit && hit);
        unique case (funct3_q)
            3'b000:         taken_nxt = eq_nxt;
            3'b001:         taken_nxt = !eq_nxt;
            3'b100, 3'b110: taken_nxt = lt_nxt;
            3'b101, 3'b111: taken_nxt = !lt_nxt;
            default:        taken_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            a_q          <= '0;
            b_q          <= '0;
            funct3_q     <= '0;
            k_q          <= '0;
            dec_q        <= 1'b0;
            lt_q         <= 1'b0;
            eq_q         <= 1'b0;
            taken_q      <= 1'b0;
            done_valid_q <= 1'b0;
        end else if (accept) begin
            state_q      <= StRun;
            a_q          <= a_i;
            b_q          <= b_i;
            funct3_q     <= funct3_i;
            k_q          <= '0;
            dec_q        <= 1'b0;
            lt_q         <= 1'b0;
            eq_q         <= 1'b1;
            done_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StRun: begin
                    a_q   <= a_q << CHUNK;
                    b_q   <= b_q << CHUNK;
                    k_q   <= k_q + KW'(1);
                    dec_q <= dec_q || hit;
                    lt_q  <= lt_nxt;
                    eq_q  <= eq_nxt;
                    if (last) begin
                        state_q      <= StDone;
                        taken_q      <= taken_nxt;
                        done_valid_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (done_ready_i) begin
                        state_q      <= StIdle;
                        done_valid_q <= 1'b0;
                    end
                end
                StIdle:  ;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign done_valid_o = done_valid_q;
    assign taken_o      = taken_q;
    assign lt_o         = lt_q;
    assign eq_o         = eq_q;

endmodule
